// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and next-address stage of the single-cycle datapath. PC
//   drives the instruction memory address. The Instruction word that memory
//   returns for PC, together with the branch resolution, selects the next PC.
//   The next PC is PC+4, the branch target or the jump target, in the priority
//   order jump > branch > sequential.
//   A small FSM (RUN / HALT / ERROR) handles two cases:
//   - A jump-to-self ends the program and the unit enters HALT.
//   - A fetch address beyond the instruction memory puts the unit in ERROR.
//   Only reset leaves HALT or ERROR.
//
// Optional feature macro: HALT_DETECT_EN
//   defined   : jump-to-self is detected and moves the FSM to HALT.
//   undefined : there is no HALT state and Halted is tied low. A jump-to-self
//               reloads the same PC on every non-stalled cycle and keeps
//               counting fetches.
//
// Parameters
//   RESET_PC     PC loaded on reset (word aligned)
//   IMEM_WORDS   instruction memory depth in words; legal PCs are 0..IMEM_WORDS*4-4
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset, wins over every other input
//   Stall         hold PC, state and FetchCount this cycle
//   BranchTaken   branch condition of the current instruction resolved true
//   BranchOffset  sign-extended word offset of the current instruction
//   Instruction   word returned by instruction memory for PC
//   PC            current fetch address (instruction memory Address)
//   PCPlus4       PC + 4, combinational
//   Halted        high while in HALT (registered state decode)
//   AddrError     high while in ERROR (registered state decode)
//   FetchCount    count of retired fetches, wraps at 2^32
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchOffset,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Halted,
  output logic        AddrError,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_ERROR = 2'b10
  } state_e;

  // Computed one bit wider so that IMEM_WORDS*4 == 2^32 stays representable.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        is_jump;
  logic        in_range;

  // Next-address datapath
  assign pc_plus4      = pc_q + 32'd4;
  assign is_jump       = (Instruction[31:26] == 6'h02) || (Instruction[31:26] == 6'h03);
  assign jump_target   = {pc_plus4[31:28], Instruction[25:0], 2'b00};
  assign branch_target = pc_plus4 + (BranchOffset << 2);
  assign next_pc       = is_jump     ? jump_target   :
                         BranchTaken ? branch_target : pc_plus4;
  assign in_range      = ({1'b0, next_pc} < PC_LIMIT);

  // State register
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples the values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: hold values are assigned first so that no path leaves a signal
    // unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (!Stall) begin
          cnt_d = cnt_q + 32'd1;
          if (!in_range) begin
            state_d = ST_ERROR;      // PC keeps the offending instruction's address
          end
`ifdef HALT_DETECT_EN
          else if (next_pc == pc_q) begin
            state_d = ST_HALT;       // jump-to-self: end of program
          end
`endif
          else begin
            pc_d = next_pc;
          end
        end
      end
      ST_HALT, ST_ERROR: ;           // frozen until reset
      default: state_d = ST_ERROR;   // unused encoding
    endcase
  end

  // Output decode
  always_comb begin
    PC         = pc_q;
    PCPlus4    = pc_plus4;
    FetchCount = cnt_q;
`ifdef HALT_DETECT_EN
    Halted     = (state_q == ST_HALT);
`else
    Halted     = 1'b0;
`endif
    AddrError  = (state_q == ST_ERROR);
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam logic [31:0] NJ = 32'h2001_000A;   // non-jump instruction

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchOffset;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Halted;
  logic        AddrError;
  logic [31:0] FetchCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        h;
    logic        e;
  } exp_t;

  exp_t sb[$];

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchOffset(BranchOffset),
    .Instruction (Instruction),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .Halted      (Halted),
    .AddrError   (AddrError),
    .FetchCount  (FetchCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the next edge must produce,
  // then compare against the DUT shortly after that edge.
  task automatic step(input string tag, input logic rst, input logic stall,
                      input logic br, input logic [31:0] off, input logic [31:0] instr,
                      input logic [31:0] exp_pc, input logic [31:0] exp_cnt,
                      input logic exp_h, input logic exp_e);
    exp_t x;
    reset        = rst;
    Stall        = stall;
    BranchTaken  = br;
    BranchOffset = off;
    Instruction  = instr;
    x.tag = tag; x.pc = exp_pc; x.cnt = exp_cnt; x.h = exp_h; x.e = exp_e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check({x.tag, "_pc"},   PC,                x.pc);
      check({x.tag, "_cnt"},  FetchCount,        x.cnt);
      check({x.tag, "_halt"}, {31'd0, Halted},   {31'd0, x.h});
      check({x.tag, "_err"},  {31'd0, AddrError}, {31'd0, x.e});
      check({x.tag, "_pc4"},  PCPlus4,           x.pc + 32'd4);
    end
  endtask

  initial begin
    // Reset state
    step("reset",   1, 0, 0, 0, NJ, 32'h00, 0, 0, 0);

    // Sequential fetch
    step("seq1",    0, 0, 0, 0, NJ, 32'h04, 1, 0, 0);
    step("seq2",    0, 0, 0, 0, NJ, 32'h08, 2, 0, 0);
    step("seq3",    0, 0, 0, 0, NJ, 32'h0C, 3, 0, 0);

    // Jump back to 0x8, then stall three cycles with jump + branch asserted
    step("jmp8",    0, 0, 0, 0, 32'h0800_0002, 32'h08, 4, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 1, 32'd2, 32'h0800_0005, 32'h08, 4, 0, 0);
    step("unstall", 0, 0, 0, 0, 32'h0800_0005, 32'h14, 5, 0, 0);

    // Branch taken from 0x18: 0x1C + 8
    step("to18",    0, 0, 0, 0, NJ, 32'h18, 6, 0, 0);
    step("branch",  0, 0, 1, 32'd2, NJ, 32'h24, 7, 0, 0);

    // Jump beats branch at 0x1C
    step("jmp1c",   0, 0, 0, 0, 32'h0800_0007, 32'h1C, 8, 0, 0);
    step("jvb",     0, 0, 1, 32'd2, 32'h0800_000A, 32'h28, 9, 0, 0);

    // Negative branch offset: 0x2C - 12
    step("brneg",   0, 0, 1, 32'hFFFF_FFFD, NJ, 32'h20, 10, 0, 0);
    step("jmp24",   0, 0, 0, 0, 32'h0800_0009, 32'h24, 11, 0, 0);

    // Jump-to-self at 0x24
`ifdef HALT_DETECT_EN
    step("halt",    0, 0, 0, 0, 32'h0800_0009, 32'h24, 12, 1, 0);
    for (int i = 0; i < 10; i++)
      step("halted", 0, i[1], i[0], 32'd3, (i[2] ? NJ : 32'h0800_0009), 32'h24, 12, 1, 0);
`else
    step("self",    0, 0, 0, 0, 32'h0800_0009, 32'h24, 12, 0, 0);
    for (int i = 0; i < 10; i++)
      step("selfloop", 0, 0, i[0], 32'd3, 32'h0800_0009, 32'h24, 32'(13 + i), 0, 0);
`endif

    // Reset from HALT (or mid-run)
    step("rst_halt", 1, 0, 1, 32'd3, 32'h0800_0009, 32'h00, 0, 0, 0);

    // Range error: jump to last legal word 0x3C, then fall through to 0x40
    step("to3c",    0, 0, 0, 0, 32'h0800_000F, 32'h3C, 1, 0, 0);
    step("range",   0, 0, 0, 0, NJ, 32'h3C, 2, 0, 1);
    for (int i = 0; i < 4; i++)
      step("errhold", 0, i[0], i[1], 32'd1, 32'h0800_0002, 32'h3C, 2, 0, 1);

    // Reset from ERROR
    step("rst_err", 1, 0, 0, 0, NJ, 32'h00, 0, 0, 0);

    // Reset wins over stall
    step("adv",     0, 0, 0, 0, NJ, 32'h04, 1, 0, 0);
    step("rst_stl", 1, 1, 1, 32'd5, 32'h0800_0005, 32'h00, 0, 0, 0);

    // Out-of-range jump target
    step("jmpoor",  0, 0, 0, 0, 32'h0800_0040, 32'h00, 1, 0, 1);
    step("rst_end", 1, 0, 0, 0, NJ, 32'h00, 0, 0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
